// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO stream reader: skid depth, pointer and occupancy.
package fifo_stream_pkg;

    localparam int unsigned SKID_DEPTH = 3;

    typedef logic [1:0] ptr_t;
    typedef logic [1:0] occ_t;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == ptr_t'(SKID_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buffer3.sv
// Three-entry circular skid buffer; clear empties it, reset also zeroes storage.
module skid_buffer3
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output occ_t             occ
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    ptr_t             rd_ptr;
    ptr_t             wr_ptr;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            if (reset) begin
                for (int i = 0; i < SKID_DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + occ_t'(1);
                2'b01:   occ <= occ - occ_t'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Turns a registered-read FIFO into a valid/ready stream via a 3-deep skid buffer.
// Define FIFO_STREAM_READER_STATS_EN to add xfer_count/stall_count outputs.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_rd_en,
    input  logic             flush,
    input  logic             m_ready,
    output logic             m_valid,
`ifdef FIFO_STREAM_READER_STATS_EN
    output logic [WIDTH-1:0] m_data,
    output logic [31:0]      xfer_count,
    output logic [31:0]      stall_count
`else
    output logic [WIDTH-1:0] m_data
`endif
);

    logic       inflight;
    occ_t       occ;
    logic [2:0] committed;
    logic       push;
    logic       pop;

    // Credit check uses only registered state, so m_ready never reaches fifo_rd_en.
    assign committed  = 3'(occ) + 3'(inflight);
    assign fifo_rd_en = !fifo_empty && !flush && !reset
                        && (committed < 3'(SKID_DEPTH));

    assign push    = inflight && !flush && !reset;
    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    skid_buffer3 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (fifo_data_out),
        .dout  (m_data),
        .occ   (occ)
    );

`ifdef FIFO_STREAM_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_count  <= '0;
            stall_count <= '0;
        end else begin
            if (pop) begin
                xfer_count <= xfer_count + 32'd1;
            end
            if (m_valid && !m_ready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader against a queue model.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data_out = '0;
    logic        fifo_rd_en;
    logic        flush = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_valid;
    logic [31:0] m_data;
`ifdef FIFO_STREAM_READER_STATS_EN
    logic [31:0] xfer_count;
    logic [31:0] stall_count;
`endif

    fifo_stream_reader #(
        .WIDTH (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_rd_en    (fifo_rd_en),
        .flush         (flush),
        .m_ready       (m_ready),
        .m_valid       (m_valid),
`ifdef FIFO_STREAM_READER_STATS_EN
        .m_data        (m_data),
        .xfer_count    (xfer_count),
        .stall_count   (stall_count)
`else
        .m_data        (m_data)
`endif
    );

    always #5 clk = ~clk;

    // Environment FIFO contents and the reference view of the reader.
    logic [31:0] fq [$];
    logic [31:0] mq [$];
    logic        pend = 1'b0;
    logic [31:0] pend_w = '0;
    logic [31:0] m_xfer = '0;
    logic [31:0] m_stall = '0;
    logic        armed = 1'b0;

    logic        obs_rd;
    logic        obs_valid;
    logic [31:0] obs_data;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic fl, input logic rdy,
                         input logic gate);
        logic exp_rd;
        logic exp_valid;
        @(negedge clk);
        reset      = rst;
        flush      = fl;
        m_ready    = rdy;
        fifo_empty = (fq.size() == 0) || gate;
        #1;
        exp_valid = (mq.size() != 0);
        exp_rd    = !fifo_empty && !rst && !fl
                    && ((mq.size() + (pend ? 1 : 0)) < 3);
        obs_rd    = fifo_rd_en;
        obs_valid = m_valid;
        obs_data  = m_data;
        if (armed) begin
            chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
            chk("m_valid", 32'(m_valid), 32'(exp_valid));
            if (exp_valid) chk("m_data", m_data, mq[0]);
`ifdef FIFO_STREAM_READER_STATS_EN
            chk("xfer_count", xfer_count, m_xfer);
            chk("stall_count", stall_count, m_stall);
`endif
        end
        @(posedge clk);
        if (rst) begin
            m_xfer  = '0;
            m_stall = '0;
            armed   = 1'b1;
        end else if (exp_valid && rdy) begin
            m_xfer = m_xfer + 32'd1;
        end else if (exp_valid) begin
            m_stall = m_stall + 32'd1;
        end
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (exp_valid && rdy) void'(mq.pop_front());
            if (pend) mq.push_back(pend_w);
        end
        pend = obs_rd;
        if (obs_rd && fq.size() > 0) pend_w = fq.pop_front();
        #1;
        if (obs_rd) fifo_data_out = pend_w;
    endtask

    task automatic do_reset();
        fq.delete();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) fq.push_back(32'(first + i));
    endtask

    task automatic first_valid(input int budget, output logic [31:0] d,
                               output logic found);
        found = 1'b0;
        d     = '0;
        for (int i = 0; i < budget && !found; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            if (obs_valid) begin
                found = 1'b1;
                d     = obs_data;
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        found;
        int          rd_at;
        int          pulses;
        int          bad;
        int          k;

        // Reset state and empty FIFO
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("reset_m_data", obs_data, 32'h0);
        chk("reset_m_valid", 32'(obs_valid), 32'h0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            if (obs_rd || obs_valid) bad++;
        end
        chk("empty_quiet", 32'(bad), 32'h0);

        // Streaming 1..8 at full rate
        do_reset();
        load(1, 8);
        rd_at = -1;
        k = 0;
        bad = 0;
        for (int c = 0; c < 14; c++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            if (obs_rd && rd_at < 0) rd_at = c;
            if (obs_valid) begin
                if (c != 2 + k || obs_data != 32'(k + 1)) bad++;
                k++;
            end
        end
        chk("stream_first_rd", 32'(rd_at), 32'h0);
        chk("stream_words", 32'(k), 32'd8);
        chk("stream_order", 32'(bad), 32'h0);

        // Backpressure with 5 words queued
        do_reset();
        load(1, 5);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (obs_rd) pulses++;
        end
        chk("bp_pulses", 32'(pulses), 32'd3);
        chk("bp_valid", 32'(obs_valid), 32'h1);
        chk("bp_data", obs_data, 32'h1);
        k = 0;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            if (obs_valid) begin
                if (obs_data != 32'(k + 1)) bad++;
                k++;
            end
        end
        chk("bp_drain_words", 32'(k), 32'd5);
        chk("bp_drain_order", 32'(bad), 32'h0);

        // Flush with two buffered words and one in flight
        do_reset();
        load(32'h11, 6);
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("flush_valid", 32'(obs_valid), 32'h0);
        first_valid(10, d, found);
        chk("flush_found", 32'(found), 32'h1);
        chk("flush_next", d, 32'h14);

        // Reset while word 3 is on the output
        do_reset();
        load(1, 8);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            found = obs_valid && (obs_data == 32'h3);
        end
        chk("rst_mid_seen3", 32'(found), 32'h1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst_mid_rd", 32'(obs_rd), 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("rst_mid_rd2", 32'(obs_rd), 32'h0);
        chk("rst_mid_valid", 32'(obs_valid), 32'h0);
        first_valid(10, d, found);
        chk("rst_mid_resume", d, 32'h6);

`ifdef FIFO_STREAM_READER_STATS_EN
        // Eight transfers with two stall cycles
        do_reset();
        load(1, 8);
        for (int c = 0; c < 14; c++) begin
            cycle(1'b0, 1'b0, (c != 4 && c != 5), 1'b0);
        end
        chk("stats_xfer", xfer_count, 32'd8);
        chk("stats_stall", stall_count, 32'd2);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (fq.size() < 4) fq.push_back($urandom);
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
